// File: rtl/relojes_pkg.sv
// Shared types and default timing for the PLL reset/lock supervisor.
// The default timing assumes a 50 MHz reference clock.
package relojes_pkg;

   typedef enum logic [2:0] {
      PLLRST,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAIL
   } sup_state_t;

   localparam int unsigned DEF_PLL_RST_CYCLES = 64;
   localparam int unsigned DEF_LOCK_TIMEOUT   = 1048576;
   localparam int unsigned DEF_STABLE_CYCLES  = 4096;
   localparam int unsigned DEF_MAX_RETRIES    = 7;

   function automatic int unsigned max_of3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Counter widths never collapse to zero bits, even for degenerate parameters.
   function automatic int unsigned clog2_min1(input int unsigned v);
      int unsigned w;
      w = $clog2(v);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for level signals such as PLL locked indications.
// Both flops reset asynchronously to 0, so a reset always reads as "not locked".
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset and lock supervisor: drives the PLL reset, retries lock acquisition
// on timeout and releases the core reset only after lock has been stable.
module pll_supervisor
   import relojes_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       core_rst,
   output logic       ready,
   output logic       fail,
   output logic [7:0] lock_lost_cnt
);

   localparam int unsigned CW = clog2_min1(max_of3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
   localparam int unsigned RW = clog2_min1(MAX_RETRIES + 1);

   localparam logic [CW-1:0] PRST_LAST    = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

   sup_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [RW-1:0] retry_q, retry_d, retry_inc;
   logic [7:0]    lost_d;
   logic          cnt_run;
   logic          locked_s;

   // PLL handshake: pll_rst high holds the PLL in reset; after release we only
   // trust pll_locked once it has crossed into refclk through sync2.
   sync2 u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   assign retry_inc = retry_q + RW'(1);

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      lost_d  = lock_lost_cnt;
      cnt_run = 1'b0;
      case (state_q)
         PLLRST: begin
            cnt_run = 1'b1;
            if (cnt_q == PRST_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            cnt_run = 1'b1;
            // Lock has priority over a timeout landing on the same cycle.
            if (locked_s) begin
               state_d = STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RETRY_LIMIT) ? FAIL : PLLRST;
            end
         end
         STABLE: begin
            cnt_run = 1'b1;
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = RUN;
               retry_d = '0;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_d = PLLRST;
               if (lock_lost_cnt != 8'hFF) lost_d = lock_lost_cnt + 8'd1;
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = PLLRST;
         end
      endcase
   end

   // Outputs are decoded from the next state so they switch on the transition edge.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q       <= PLLRST;
         cnt_q         <= '0;
         retry_q       <= '0;
         pll_rst       <= 1'b1;
         core_rst      <= 1'b1;
         ready         <= 1'b0;
         fail          <= 1'b0;
         lock_lost_cnt <= 8'd0;
      end else begin
         state_q       <= state_d;
         retry_q       <= retry_d;
         lock_lost_cnt <= lost_d;
         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (cnt_run) begin
            cnt_q <= cnt_q + CW'(1);
         end
         pll_rst  <= (state_d == PLLRST) || (state_d == FAIL);
         core_rst <= (state_d != RUN);
         ready    <= (state_d == RUN);
         fail     <= (state_d == FAIL);
      end
   end

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: a time-stamp based reference model checked every
// cycle, plus directed scenarios with hand-computed edge indices.
module tb_pll_supervisor;

   localparam int PRST = 4;
   localparam int TMO  = 32;
   localparam int STAB = 16;
   localparam int MAXR = 3;
   localparam logic [11:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst, core_rst, ready, fail;
   logic [7:0] lock_lost_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   // ---------------- clock / reset ----------------
   always #5 refclk = ~refclk;

   pll_supervisor #(
      .PLL_RST_CYCLES (PRST),
      .LOCK_TIMEOUT   (TMO),
      .STABLE_CYCLES  (STAB),
      .MAX_RETRIES    (MAXR)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .pll_locked    (pll_locked),
      .pll_rst       (pll_rst),
      .core_rst      (core_rst),
      .ready         (ready),
      .fail          (fail),
      .lock_lost_cnt (lock_lost_cnt)
   );

   // ---------------- reference model ----------------
   // Phases are tracked by the edge number they began on; each rule is a
   // comparison of elapsed edges against the timing parameter.
   typedef enum int {M_PULSE, M_ACQ, M_QUAL, M_UP, M_DEAD} phase_t;

   phase_t      ph = M_PULSE;
   int          edge_n = 0;
   int          phase_start = 0;
   int          tries = 0;
   int          lost = 0;
   logic        samples[$];
   logic [11:0] exp_q[$];

   function automatic void model_reset();
      samples.delete();
      ph          = M_PULSE;
      edge_n      = 0;
      phase_start = 0;
      tries       = 0;
      lost        = 0;
   endfunction

   function automatic void enter(input phase_t p);
      ph          = p;
      phase_start = edge_n;
   endfunction

   function automatic void model_step(input logic sample);
      logic ls;
      int   el;
      edge_n++;
      samples.push_back(sample);
      // the FSM acts on the pin value sampled two edges earlier
      ls = (samples.size() >= 3) ? samples[samples.size() - 3] : 1'b0;
      if (samples.size() > 3) void'(samples.pop_front());
      el = edge_n - phase_start;
      case (ph)
         M_PULSE: if (el == PRST) enter(M_ACQ);
         M_ACQ: begin
            if (ls) enter(M_QUAL);
            else if (el == TMO) begin
               tries++;
               enter((tries == MAXR) ? M_DEAD : M_PULSE);
            end
         end
         M_QUAL: begin
            if (!ls) enter(M_ACQ);
            else if (el == STAB) begin
               tries = 0;
               enter(M_UP);
            end
         end
         M_UP: begin
            if (!ls) begin
               if (lost < 255) lost++;
               enter(M_PULSE);
            end
         end
         default: ;
      endcase
   endfunction

   function automatic logic [11:0] model_outputs();
      return {(ph == M_PULSE) || (ph == M_DEAD), ph != M_UP, ph == M_UP, ph == M_DEAD, 8'(lost)};
   endfunction

   always @(posedge rst) model_reset();

   always @(posedge refclk) begin
      if (rst) begin
         model_reset();
         exp_q.push_back(RESET_VEC);
      end else begin
         model_step(pll_locked);
         exp_q.push_back(model_outputs());
      end
   end

   // ---------------- scoreboard ----------------
   always @(negedge refclk) begin
      logic [11:0] e, got;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (rst) e = RESET_VEC;
         got = {pll_rst, core_rst, ready, fail, lock_lost_cnt};
         tests_run++;
         if (got !== e) begin
            tests_failed++;
            $display("FAIL model_cycle t=%0t: got pr=%b cr=%b rdy=%b f=%b llc=%0d, expected pr=%b cr=%b rdy=%b f=%b llc=%0d",
                     $time, got[11], got[10], got[9], got[8], got[7:0], e[11], e[10], e[9], e[8], e[7:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge refclk);
   endtask

   // Assert rst between edges, then release exactly on a negedge (edge index 0).
   task automatic do_reset();
      @(negedge refclk);
      #2 rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   task automatic wait_ready(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge refclk);
         if (ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int   pr_fall, cr_fall, pr_rerise, lat, hold, fail_at;
      int   falls[$], rises[$];
      logic prev, ok;

      // reset state
      cycles(3);
      check("reset_pll_rst", pll_rst, 1);
      check("reset_core_rst", core_rst, 1);
      check("reset_ready", ready, 0);
      check("reset_fail", fail, 0);
      check("reset_lock_lost_cnt", lock_lost_cnt, 0);

      // normal bring-up: lock 10 cycles after release
      rst = 1'b0;
      pr_fall = -1;
      cr_fall = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge refclk);
         if (pll_rst === 1'b0 && pr_fall < 0) pr_fall = k;
         if (core_rst === 1'b0 && cr_fall < 0) cr_fall = k;
         if (k == 10) pll_locked = 1'b1;
      end
      check("bringup_pll_rst_len", pr_fall, 4);
      check("bringup_core_rst_release", cr_fall, 29);
      check("bringup_ready", ready, 1);
      check("bringup_fail", fail, 0);
      check("bringup_lock_lost_cnt", lock_lost_cnt, 0);

      // one-cycle glitch while qualifying lock
      pll_locked = 1'b0;
      do_reset();
      pr_fall = -1;
      cr_fall = -1;
      pr_rerise = 0;
      for (int k = 1; k <= 70; k++) begin
         @(negedge refclk);
         if (pll_rst === 1'b0 && pr_fall < 0) pr_fall = k;
         if (pll_rst === 1'b1 && pr_fall > 0) pr_rerise = 1;
         if (core_rst === 1'b0 && cr_fall < 0) cr_fall = k;
         if (k == 10) pll_locked = 1'b1;
         if (k == 21) pll_locked = 1'b0;
         if (k == 22) pll_locked = 1'b1;
      end
      check("glitch_core_rst_release", cr_fall, 41);
      check("glitch_no_pll_rst_pulse", pr_rerise, 0);

      // repeated lock loss in RUN
      for (int i = 0; i < 300; i++) begin
         cycles($urandom_range(1, 5));
         pll_locked = 1'b0;
         hold = $urandom_range(1, 8);
         lat = -1;
         for (int k = 1; k <= 8; k++) begin
            @(negedge refclk);
            if (core_rst === 1'b1 && lat < 0) lat = k;
            if (k == hold) pll_locked = 1'b1;
         end
         check("loss_core_rst_latency", lat, 3);
         wait_ready(100, ok);
         check("loss_relock_ready", ok, 1);
      end
      check("loss_cnt_saturated", lock_lost_cnt, 255);

      // async reset while waiting for lock, after one timeout has been spent
      pll_locked = 1'b0;
      cycles(50);
      #2 rst = 1'b1;
      #1;
      check("async_pll_rst", pll_rst, 1);
      check("async_core_rst", core_rst, 1);
      check("async_ready", ready, 0);
      check("async_lock_lost_cnt", lock_lost_cnt, 0);
      cycles(2);
      rst = 1'b0;

      // retry exhaustion from a fresh start: three full timeouts needed
      prev = 1'b1;
      fail_at = -1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge refclk);
         if (prev === 1'b1 && pll_rst === 1'b0) falls.push_back(k);
         if (prev === 1'b0 && pll_rst === 1'b1) rises.push_back(k);
         if (fail === 1'b1 && fail_at < 0) fail_at = k;
         prev = pll_rst;
      end
      check("retry_pulse_count", falls.size(), 3);
      if (falls.size() == 3) begin
         check("retry_fall0", falls[0], 4);
         check("retry_fall1", falls[1], 40);
         check("retry_fall2", falls[2], 76);
      end
      check("retry_rise_count", rises.size(), 3);
      if (rises.size() == 3) check("retry_final_rise", rises[2], 108);
      check("retry_fail_at", fail_at, 108);
      check("retry_final_pll_rst", pll_rst, 1);
      check("retry_final_core_rst", core_rst, 1);
      check("retry_final_fail", fail, 1);
      #2 rst = 1'b1;
      #1;
      check("fail_cleared_by_rst", fail, 0);
      cycles(2);
      rst = 1'b0;

      // random lock behaviour with occasional async resets
      for (int i = 0; i < 3000; i++) begin
         @(negedge refclk);
         if ($urandom_range(0, 99) < 6) pll_locked = ~pll_locked;
         if ($urandom_range(0, 999) < 3) begin
            #2 rst = 1'b1;
            cycles($urandom_range(1, 2));
            rst = 1'b0;
         end
      end

      cycles(2);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      tests_run++;
      tests_failed++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
